instruction_fetch_unit: RTL and testbench

Sequences the 16-bit program counter: fetches instruction words from instruction memory at the current counter value and resolves control flow locally. Relative branches, conditional relative branches, absolute jumps and halt are handled in this block. All other instructions go to the execute stage over a valid/ready handshake. Each cycle it drives the counter's load/offset controls; the counter self-increments when neither control is asserted, and the counter is stalled by loading its own current value.

---
 rtl/instruction_fetch_unit.sv | 131 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch sequencer: drives an external program counter, fetches words, resolves
// branches, jumps and halt locally, and hands other instructions to execute over valid/ready.
module instruction_fetch_unit #(
    parameter logic [3:0] OPC_BR   = 4'hC,
    parameter logic [3:0] OPC_BRZ  = 4'hD,
    parameter logic [3:0] OPC_JMP  = 4'hE,
    parameter logic [3:0] OPC_HALT = 4'hF
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] PcValue,
    output logic        PcLoadEnable,
    output logic [15:0] PcLoadValue,
    output logic        PcOffsetEnable,
    output logic [8:0]  PcOffset,
    output logic        MemReq,
    output logic [15:0] MemAddr,
    input  logic        MemAck,
    input  logic [15:0] MemData,
    input  logic        Zero,
    output logic        InstrValid,
    output logic [15:0] InstrOut,
    output logic [15:0] InstrAddr,
    input  logic        InstrReady,
    output logic        Halted
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StFetchOp,
        StIssue,
        StHalt
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] addr_q, addr_d;
    logic        mem_req_q, mem_req_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;

    assign MemAddr    = PcValue;
    assign MemReq     = mem_req_q;
    assign InstrValid = valid_q;
    assign Halted     = halted_q;
    assign InstrOut   = ir_q;
    assign InstrAddr  = addr_q;

    // Default is "hold": the counter reloads its own value unless a state steps or branches.
    always_comb begin
        state_d        = state_q;
        ir_d           = ir_q;
        addr_d         = addr_q;
        PcLoadEnable   = 1'b1;
        PcLoadValue    = PcValue;
        PcOffsetEnable = 1'b0;
        PcOffset       = 9'd0;

        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                if (MemAck) begin
                    ir_d    = MemData;
                    addr_d  = PcValue;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                state_d = StFetch;
                case (ir_q[15:12])
                    OPC_BR: begin
                        PcLoadEnable   = 1'b0;
                        PcOffsetEnable = 1'b1;
                        PcOffset       = ir_q[8:0];
                    end
                    OPC_BRZ: begin
                        PcLoadEnable   = 1'b0;
                        PcOffsetEnable = Zero;
                        PcOffset       = Zero ? ir_q[8:0] : 9'd0;
                    end
                    OPC_JMP: begin
                        PcLoadEnable = 1'b0;
                        state_d      = StFetchOp;
                    end
                    OPC_HALT: state_d = StHalt;
                    default:  state_d = StIssue;
                endcase
            end
            StFetchOp: begin
                // Jump target is loaded straight from the bus; it is never stored.
                if (MemAck) begin
                    PcLoadValue = MemData;
                    state_d     = StFetch;
                end
            end
            StIssue: begin
                if (InstrReady) begin
                    PcLoadEnable = 1'b0;
                    state_d      = StFetch;
                end
            end
            StHalt:  state_d = StHalt;
            default: state_d = StIdle;
        endcase

        mem_req_d = (state_d == StFetch) || (state_d == StFetchOp);
        valid_d   = (state_d == StIssue);
        halted_d  = (state_d == StHalt);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= StIdle;
            ir_q      <= 16'd0;
            addr_q    <= 16'd0;
            mem_req_q <= 1'b0;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            addr_q    <= addr_d;
            mem_req_q <= mem_req_d;
            valid_q   <= valid_d;
            halted_q  <= halted_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: external counter and memory models, fetch/issue scoreboards.
module tb_instruction_fetch_unit;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] PcValue;
    logic        PcLoadEnable;
    logic [15:0] PcLoadValue;
    logic        PcOffsetEnable;
    logic [8:0]  PcOffset;
    logic        MemReq;
    logic [15:0] MemAddr;
    logic        MemAck = 1'b0;
    logic [15:0] MemData = 16'd0;
    logic        Zero = 1'b0;
    logic        InstrValid;
    logic [15:0] InstrOut;
    logic [15:0] InstrAddr;
    logic        InstrReady = 1'b0;
    logic        Halted;

    instruction_fetch_unit dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .PcValue       (PcValue),
        .PcLoadEnable  (PcLoadEnable),
        .PcLoadValue   (PcLoadValue),
        .PcOffsetEnable(PcOffsetEnable),
        .PcOffset      (PcOffset),
        .MemReq        (MemReq),
        .MemAddr       (MemAddr),
        .MemAck        (MemAck),
        .MemData       (MemData),
        .Zero          (Zero),
        .InstrValid    (InstrValid),
        .InstrOut      (InstrOut),
        .InstrAddr     (InstrAddr),
        .InstrReady    (InstrReady),
        .Halted        (Halted)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // External program counter
    logic [15:0] pc;
    assign PcValue = pc;
    always @(posedge Clock or posedge Reset) begin
        if (Reset)               pc <= 16'd0;
        else if (PcLoadEnable)   pc <= PcLoadValue;
        else if (PcOffsetEnable) pc <= pc + {{7{PcOffset[8]}}, PcOffset};
        else                     pc <= pc + 16'd1;
    end

    // Memory, scoreboards and execute-side ready
    logic [15:0] mem [logic [15:0]];
    logic [15:0] fq[$];
    logic [31:0] iq[$];
    int   lat = 3;
    int   cnt = 0;
    int   vcnt = 0;
    int   ready_delay = 0;
    bit   parked = 0;
    bit   ack_all = 0;
    bit   force_ack = 0;

    function automatic logic [15:0] rd(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : 16'h0000;
    endfunction

    always @(negedge Clock) begin
        logic [15:0] ef;
        logic [31:0] ei;
        MemAck = 1'b0;
        if (force_ack) begin
            MemAck    = 1'b1;
            MemData   = 16'hC0FF;
            force_ack = 0;
        end else if (Reset || !MemReq) begin
            cnt = 0;
        end else if (!parked) begin
            if (cnt >= lat - 1) begin
                cnt = 0;
                if (fq.size() == 0) begin
                    check("extra_fetch", {16'd0, MemAddr}, 32'hFFFF_FFFF);
                    parked = 1;
                end else begin
                    ef = fq.pop_front();
                    check("fetch_addr", {16'd0, MemAddr}, {16'd0, ef});
                    if (fq.size() > 0 || ack_all) begin
                        MemAck  = 1'b1;
                        MemData = rd(MemAddr);
                    end else begin
                        parked = 1;
                    end
                end
            end else begin
                cnt++;
            end
        end
        if (InstrValid) begin
            InstrReady = (vcnt >= ready_delay);
            vcnt++;
        end else begin
            InstrReady = 1'b0;
            vcnt = 0;
        end
        if (InstrValid && InstrReady) begin
            if (iq.size() == 0) begin
                check("extra_issue", {InstrOut, InstrAddr}, 32'hFFFF_FFFF);
            end else begin
                ei = iq.pop_front();
                check("issue", {InstrOut, InstrAddr}, ei);
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic wait_fetches(input string name);
        int n = 0;
        while (fq.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        check(name, fq.size(), 0);
    endtask

    typedef struct {
        string       name;
        logic [15:0] a0, d0, a1, d1, a2, d2;
        logic        zero;
        int          lat;
        int          nf;
        logic [15:0] f0, f1, f2, f3;
        logic        iss;
        logic [15:0] iw, ia;
        logic        ack_all;
        logic        halt;
    } vec_t;

    vec_t vecs[12];

    task automatic run_vec(input vec_t v);
        logic [15:0] f[4];
        Reset = 1'b1;
        tick();
        mem.delete();
        fq.delete();
        iq.delete();
        parked      = 0;
        lat         = v.lat;
        Zero        = v.zero;
        ack_all     = v.ack_all;
        ready_delay = 0;
        mem[v.a0] = v.d0;
        mem[v.a1] = v.d1;
        mem[v.a2] = v.d2;
        f[0] = v.f0; f[1] = v.f1; f[2] = v.f2; f[3] = v.f3;
        for (int i = 0; i < v.nf; i++) fq.push_back(f[i]);
        if (v.iss) iq.push_back({v.iw, v.ia});
        Reset = 1'b0;
        wait_fetches({v.name, "_timeout"});
        repeat (10) tick();
        check({v.name, "_issues_left"}, iq.size(), 0);
        check({v.name, "_halted"}, {31'd0, Halted}, {31'd0, v.halt});
        if (v.halt) check({v.name, "_halt_quiet"}, {30'd0, MemReq, InstrValid}, 32'd0);
    endtask

    initial begin
        int nreq;
        int nval;
        vecs[0]  = '{"plain",     16'h0, 16'h1234, 16'h0, 16'h1234, 16'h0, 16'h1234, 1'b0, 3, 2,
                     16'h0, 16'h1, 16'h0, 16'h0, 1'b1, 16'h1234, 16'h0, 1'b0, 1'b0};
        vecs[1]  = '{"plain_l1",  16'h0, 16'h7ABC, 16'h0, 16'h7ABC, 16'h0, 16'h7ABC, 1'b0, 1, 2,
                     16'h0, 16'h1, 16'h0, 16'h0, 1'b1, 16'h7ABC, 16'h0, 1'b0, 1'b0};
        vecs[2]  = '{"br_wrap",   16'h0, 16'hC1FF, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001, 1'b0,
                     2, 3, 16'h0, 16'hFFFF, 16'h0, 16'h0, 1'b1, 16'h0001, 16'hFFFF, 1'b0, 1'b0};
        vecs[3]  = '{"br_fwd",    16'h0, 16'hC005, 16'h0, 16'hC005, 16'h0, 16'hC005, 1'b0, 2, 2,
                     16'h0, 16'h5, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0};
        vecs[4]  = '{"br_self",   16'h0, 16'hC000, 16'h0, 16'hC000, 16'h0, 16'hC000, 1'b0, 2, 2,
                     16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0};
        vecs[5]  = '{"br_min",    16'h0, 16'hC100, 16'h0, 16'hC100, 16'h0, 16'hC100, 1'b0, 2, 2,
                     16'h0, 16'hFF00, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0};
        vecs[6]  = '{"br_back",   16'h0, 16'hC005, 16'h5, 16'hC1FC, 16'h5, 16'hC1FC, 1'b0, 2, 3,
                     16'h0, 16'h5, 16'h1, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0};
        vecs[7]  = '{"brz_taken", 16'h0, 16'hC002, 16'h2, 16'hD003, 16'h2, 16'hD003, 1'b1, 2, 3,
                     16'h0, 16'h2, 16'h5, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0};
        vecs[8]  = '{"brz_not",   16'h0, 16'hC002, 16'h2, 16'hD003, 16'h2, 16'hD003, 1'b0, 2, 3,
                     16'h0, 16'h2, 16'h3, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0};
        vecs[9]  = '{"jmp",       16'h0, 16'hC004, 16'h4, 16'hE000, 16'h5, 16'h8000, 1'b0, 2, 4,
                     16'h0, 16'h4, 16'h5, 16'h8000, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0};
        vecs[10] = '{"halt",      16'h0, 16'hC003, 16'h3, 16'hF000, 16'h3, 16'hF000, 1'b0, 2, 2,
                     16'h0, 16'h3, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1};
        vecs[11] = '{"issue_at6", 16'h0, 16'hC006, 16'h6, 16'h5555, 16'h6, 16'h5555, 1'b0, 2, 3,
                     16'h0, 16'h6, 16'h7, 16'h0, 1'b1, 16'h5555, 16'h6, 1'b0, 1'b0};

        // Reset state, then a plain fetch with three-cycle memory latency
        mem[16'h0] = 16'h1234;
        lat = 3;
        fq.push_back(16'h0);
        fq.push_back(16'h1);
        iq.push_back({16'h1234, 16'h0});
        tick();
        check("rst_ctrl", {27'd0, MemReq, InstrValid, Halted, PcOffsetEnable, PcLoadEnable},
              32'd1);
        check("rst_offset", {23'd0, PcOffset}, 32'd0);
        check("rst_instr", {InstrOut, InstrAddr}, 32'd0);
        check("rst_pc", {PcLoadValue, pc}, 32'd0);
        Reset = 1'b0;
        nreq = 0;
        nval = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (MemReq && MemAddr == 16'h0) nreq++;
            if (InstrValid) nval++;
        end
        check("req_cycles", nreq, 3);
        check("valid_cycles", nval, 1);
        wait_fetches("plain_timeout");
        check("plain_issues_left", iq.size(), 0);

        // Reset while a fetch is pending, with a stray acknowledge right behind it
        Reset = 1'b1;
        force_ack = 1;
        #1;
        check("midrst_clear", {InstrOut, InstrAddr}, 32'd0);
        check("midrst_req", {31'd0, MemReq}, 32'd0);
        tick();
        check("midrst_pc", {16'd0, pc}, 32'd0);
        check("midrst_ir", {16'd0, InstrOut}, 32'd0);
        mem[16'h0] = 16'h2222;
        fq.delete();
        iq.delete();
        fq.push_back(16'h0);
        fq.push_back(16'h1);
        iq.push_back({16'h2222, 16'h0});
        parked = 0;
        force_ack = 1;
        Reset = 1'b0;
        wait_fetches("restart_timeout");
        check("restart_issues_left", iq.size(), 0);

        // Execute stalls for four cycles
        Reset = 1'b1;
        tick();
        mem[16'h0] = 16'h1234;
        fq.delete();
        iq.delete();
        fq.push_back(16'h0);
        fq.push_back(16'h1);
        iq.push_back({16'h1234, 16'h0});
        parked = 0;
        ready_delay = 4;
        Reset = 1'b0;
        nval = 0;
        while (!InstrValid && nval < 50) begin
            tick();
            nval++;
        end
        for (int i = 0; i < 5; i++) begin
            check("stall_hold", {InstrValid, InstrOut[14:0], pc}, {1'b1, 15'h1234, 16'h0});
            tick();
        end
        check("stall_release", {15'd0, InstrValid, pc}, 32'h0000_0001);
        wait_fetches("stall_timeout");
        ready_delay = 0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
